// File: rtl/mem_responder_if.sv
// Bus between an initiator and mem_responder: word address, read/write strobes, write data,
// registered read data with a one-cycle valid.
interface mem_responder_if;
  logic [15:0] i_mem_addr;
  logic        i_mem_rd;
  logic        i_mem_wr;
  logic [15:0] i_mem_wrdata;
  logic [15:0] o_mem_rddata;
  logic        o_rd_valid;

  modport master (
    output i_mem_addr, i_mem_rd, i_mem_wr, i_mem_wrdata,
    input  o_mem_rddata, o_rd_valid
  );

  modport slave (
    input  i_mem_addr, i_mem_rd, i_mem_wr, i_mem_wrdata,
    output o_mem_rddata, o_rd_valid
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-mapped responder: RAM, LED reg, synchronized switches, free-running timer; 1-cycle read latency.
// No backpressure: every request is accepted on the edge it is sampled; illegal accesses set a sticky error.
module mem_responder #(
  parameter int RAM_AW   = 8,
  parameter int TIMER_EN = 1
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus,
  input  logic [7:0]     i_sw,
  output logic [7:0]     o_ledr,
  output logic           o_err
);
  localparam int          RAM_WORDS = 2 ** RAM_AW;
  localparam bit          HAS_TIMER = (TIMER_EN != 0);
  localparam logic [15:0] LED_ADDR  = 16'h1000;
  localparam logic [15:0] SW_ADDR   = 16'h2000;
  localparam logic [15:0] TMR_ADDR  = 16'h3000;

  typedef enum logic {IDLE, RESP} state_t;

  state_t      state_q, state_d;
  logic [7:0]  ledr_q, ledr_d;
  logic        err_q, err_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  sw_meta_q, sw_sync_q;
  logic [15:0] reg_rdata_q, reg_rdata_d;
  logic        sel_ram_q, sel_ram_d;
  logic [15:0] ram_rdata_q;
  logic [15:0] mem_q [RAM_WORDS];

  logic              rd_s, wr_s;
  logic              hit_ram, hit_led, hit_sw, hit_tmr, mapped;
  logic [RAM_AW-1:0] ram_idx;
  logic [15:0]       reg_rdata;

  // A write wins over a simultaneous read, so the read is only "sampled" when no write is present.
  assign wr_s    = bus.i_mem_wr;
  assign rd_s    = bus.i_mem_rd & ~bus.i_mem_wr;
  assign hit_ram = ({16'h0000, bus.i_mem_addr} < 32'(RAM_WORDS));
  assign hit_led = (bus.i_mem_addr == LED_ADDR);
  assign hit_sw  = (bus.i_mem_addr == SW_ADDR);
  assign hit_tmr = HAS_TIMER && (bus.i_mem_addr == TMR_ADDR);
  assign mapped  = hit_ram | hit_led | hit_sw | hit_tmr;
  assign ram_idx = bus.i_mem_addr[RAM_AW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = IDLE;
    ledr_d      = ledr_q;
    timer_d     = timer_q + 16'd1;
    err_d       = err_q;
    reg_rdata   = 16'h0000;
    reg_rdata_d = reg_rdata_q;
    sel_ram_d   = sel_ram_q;

    if (rd_s) state_d = RESP;

    if (wr_s && hit_led) ledr_d = bus.i_mem_wrdata[7:0];
    if (wr_s && hit_tmr) timer_d = 16'h0000;
    if (!HAS_TIMER)      timer_d = 16'h0000;

    if (bus.i_mem_rd && bus.i_mem_wr)   err_d = 1'b1;
    if (wr_s && (hit_sw || !mapped))    err_d = 1'b1;
    if (rd_s && !mapped)                err_d = 1'b1;

    if (hit_led)      reg_rdata = {8'h00, ledr_q};
    else if (hit_sw)  reg_rdata = {8'h00, sw_sync_q};
    else if (hit_tmr) reg_rdata = timer_q;

    if (rd_s) begin
      reg_rdata_d = reg_rdata;
      sel_ram_d   = hit_ram;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ledr_q      <= 8'h00;
      err_q       <= 1'b0;
      timer_q     <= 16'h0000;
      sw_meta_q   <= 8'h00;
      sw_sync_q   <= 8'h00;
      reg_rdata_q <= 16'h0000;
      sel_ram_q   <= 1'b0;
    end else begin
      ledr_q      <= ledr_d;
      err_q       <= err_d;
      timer_q     <= timer_d;
      sw_meta_q   <= i_sw;
      sw_sync_q   <= sw_meta_q;
      reg_rdata_q <= reg_rdata_d;
      sel_ram_q   <= sel_ram_d;
    end
  end

  // RAM has no reset; its output register only loads on a sampled RAM read, so it holds otherwise.
  always_ff @(posedge clk) begin
    if (rd_s && hit_ram) ram_rdata_q <= mem_q[ram_idx];
    if (wr_s && hit_ram) mem_q[ram_idx] <= bus.i_mem_wrdata;
  end

  assign bus.o_mem_rddata = sel_ram_q ? ram_rdata_q : reg_rdata_q;
  assign bus.o_rd_valid   = (state_q == RESP);
  assign o_ledr           = ledr_q;
  assign o_err            = err_q;
endmodule
